// File: rtl/nand_pkg.sv
// Shared definitions for the NAND flash target model: command codes, FSM
// states and default busy timings.
package nand_pkg;

  localparam logic [7:0] CMD_READ0 = 8'h00;
  localparam logic [7:0] CMD_READ1 = 8'h01;
  localparam logic [7:0] CMD_PROG  = 8'h80;
  localparam logic [7:0] CMD_PCONF = 8'h10;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  localparam int T_R_DEF    = 25;
  localparam int T_PROG_DEF = 200;
  localparam int T_RST_DEF  = 5;
  localparam int TMR_W      = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ADDR      = 3'd1,
    S_BUSY_R    = 3'd2,
    S_READ_DATA = 3'd3,
    S_PROG_DATA = 3'd4,
    S_BUSY_P    = 3'd5,
    S_BUSY_RST  = 3'd6
  } state_t;

  function automatic logic is_start_cmd(input logic [7:0] code);
    return (code == CMD_READ0) || (code == CMD_READ1) || (code == CMD_PROG);
  endfunction

  function automatic logic is_busy(input state_t s);
    return (s == S_BUSY_R) || (s == S_BUSY_P) || (s == S_BUSY_RST);
  endfunction

endpackage

// File: rtl/nand_busy_timer.sv
// Down-counter shared by every busy phase; o_done is high in the last busy
// cycle so the FSM leaves the busy state exactly after the loaded count.
module nand_busy_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_cnt;

  // Count register: a load always wins so a reset command restarts timing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= {W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (r_cnt != {W{1'b0}}) begin
      r_cnt <= r_cnt - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_done = (r_cnt == {{(W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/nand_target.sv
// NAND flash target: decodes CLE/ALE/WEN/REN bus cycles into page reads and
// programs against an external byte array, with ready/busy timing.
module nand_target
  import nand_pkg::*;
#(
  parameter int T_R    = T_R_DEF,
  parameter int T_PROG = T_PROG_DEF,
  parameter int T_RST  = T_RST_DEF
) (
  input  logic        clk,
  input  logic        rst,
  inout  logic [7:0]  F_IO,
  input  logic        F_CLE,
  input  logic        F_ALE,
  input  logic        F_WEN,
  input  logic        F_REN,
  output logic        F_RB,
  output logic [17:0] mem_addr,
  input  logic [7:0]  mem_rdata,
  output logic [7:0]  mem_wdata,
  output logic        mem_we
);

  localparam logic [TMR_W-1:0] LD_R    = TMR_W'(T_R);
  localparam logic [TMR_W-1:0] LD_PROG = TMR_W'(T_PROG);
  localparam logic [TMR_W-1:0] LD_RST  = TMR_W'(T_RST);

  state_t            r_state;
  state_t            w_next_state;
  logic              r_wen_prev;
  logic              r_ren_prev;
  logic              r_prog;
  logic              r_col_hi;
  logic [1:0]        r_acnt;
  logic [8:0]        r_page;
  logic [8:0]        r_col;
  logic              r_rb;
  logic              r_we;
  logic [7:0]        r_wdata;
  logic              w_we_rise;
  logic              w_re_rise;
  logic              w_cmd_ev;
  logic              w_addr_ev;
  logic              w_data_ev;
  logic              w_start;
  logic              w_rst_cmd;
  logic              w_conf_cmd;
  logic              w_oe;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_val;
  logic              w_tmr_done;

  // Bus cycles are decoded from strobe rising edges; CLE and ALE together is illegal.
  assign w_we_rise  = F_WEN & ~r_wen_prev;
  assign w_re_rise  = F_REN & ~r_ren_prev;
  assign w_cmd_ev   = w_we_rise &  F_CLE & ~F_ALE;
  assign w_addr_ev  = w_we_rise & ~F_CLE &  F_ALE;
  assign w_data_ev  = w_we_rise & ~F_CLE & ~F_ALE;
  assign w_start    = w_cmd_ev & is_start_cmd(F_IO) & ~is_busy(r_state);
  assign w_rst_cmd  = w_cmd_ev & (F_IO == CMD_RESET);
  assign w_conf_cmd = w_cmd_ev & (F_IO == CMD_PCONF);

  assign w_oe      = (r_state == S_READ_DATA) & ~F_REN & r_rb;
  assign F_IO      = w_oe ? mem_rdata : 8'hzz;
  assign F_RB      = r_rb;
  assign mem_addr  = {r_page, r_col};
  assign mem_we    = r_we;
  assign mem_wdata = r_wdata;

  nand_busy_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_tmr_load),
    .i_load_val (w_tmr_val),
    .o_done     (w_tmr_done)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic; a reset command overrides every state, including busy ones.
  always_comb begin
    w_next_state = r_state;
    if (w_rst_cmd) begin
      w_next_state = S_BUSY_RST;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) w_next_state = S_ADDR;
          else         w_next_state = r_state;
        end
        S_ADDR: begin
          if (w_start)                             w_next_state = S_ADDR;
          else if (w_addr_ev && r_acnt == 2'd2)    w_next_state = r_prog ? S_PROG_DATA : S_BUSY_R;
          else                                     w_next_state = r_state;
        end
        S_BUSY_R: begin
          if (w_tmr_done) w_next_state = S_READ_DATA;
          else            w_next_state = r_state;
        end
        S_READ_DATA: begin
          if (w_start) w_next_state = S_ADDR;
          else         w_next_state = r_state;
        end
        S_PROG_DATA: begin
          if (w_start)         w_next_state = S_ADDR;
          else if (w_conf_cmd) w_next_state = S_BUSY_P;
          else                 w_next_state = r_state;
        end
        S_BUSY_P: begin
          if (w_tmr_done) w_next_state = S_IDLE;
          else            w_next_state = r_state;
        end
        S_BUSY_RST: begin
          if (w_tmr_done) w_next_state = S_IDLE;
          else            w_next_state = r_state;
        end
        default: w_next_state = S_IDLE;
      endcase
    end
  end

  // Output decode: timer is loaded only on entry into a busy phase.
  always_comb begin
    w_tmr_load = 1'b0;
    w_tmr_val  = {TMR_W{1'b0}};
    if (w_rst_cmd) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = LD_RST;
    end else if (r_state == S_ADDR && w_next_state == S_BUSY_R) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = LD_R;
    end else if (r_state == S_PROG_DATA && w_next_state == S_BUSY_P) begin
      w_tmr_load = 1'b1;
      w_tmr_val  = LD_PROG;
    end else begin
      w_tmr_load = 1'b0;
      w_tmr_val  = {TMR_W{1'b0}};
    end
  end

  // Datapath: edge history, address capture, column stepping and write strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wen_prev <= 1'b1;
      r_ren_prev <= 1'b1;
      r_prog     <= 1'b0;
      r_col_hi   <= 1'b0;
      r_acnt     <= 2'd0;
      r_page     <= 9'd0;
      r_col      <= 9'd0;
      r_rb       <= 1'b1;
      r_we       <= 1'b0;
      r_wdata    <= 8'h00;
    end else begin
      r_wen_prev <= F_WEN;
      r_ren_prev <= F_REN;
      r_rb       <= ~is_busy(w_next_state);
      r_we       <= 1'b0;
      if (w_rst_cmd) begin
        r_acnt <= 2'd0;
        r_page <= 9'd0;
        r_col  <= 9'd0;
      end else if (w_start) begin
        r_prog   <= (F_IO == CMD_PROG);
        r_col_hi <= (F_IO == CMD_READ1);
        r_acnt   <= 2'd0;
      end else if (r_we) begin
        // Column steps the cycle after the strobe so the write sees the old address.
        r_col <= r_col + 9'd1;
      end else if (r_state == S_ADDR && w_addr_ev) begin
        r_acnt <= r_acnt + 2'd1;
        case (r_acnt)
          2'd0:    r_col       <= {r_col_hi, F_IO};
          2'd1:    r_page[7:0] <= F_IO;
          2'd2:    r_page[8]   <= F_IO[0];
          default: r_page      <= r_page;
        endcase
      end else if (r_state == S_READ_DATA && w_re_rise) begin
        r_col <= r_col + 9'd1;
      end else if (r_state == S_PROG_DATA && w_data_ev) begin
        r_we    <= 1'b1;
        r_wdata <= F_IO;
      end else begin
        r_col <= r_col;
      end
    end
  end

endmodule

// File: tb/tb_nand_target.sv
// Directed bench for nand_target: page reads, column wrap, program, reset
// command during busy, and synchronous reset during a data read.
module tb_nand_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        F_CLE, F_ALE, F_WEN, F_REN;
  wire  [7:0]  F_IO;
  logic        F_RB;
  logic [17:0] mem_addr;
  logic [7:0]  mem_rdata;
  logic [7:0]  mem_wdata;
  logic        mem_we;

  logic        tb_oe;
  logic [7:0]  tb_dq;
  logic        rd_force;
  logic [7:0]  r_mrd;
  int          tests = 0;
  int          fails = 0;
  int          we_cnt = 0;
  int          n;
  int          we_base;

  always #5 clk = ~clk;

  nand_target dut (
    .clk       (clk),
    .rst       (rst),
    .F_IO      (F_IO),
    .F_CLE     (F_CLE),
    .F_ALE     (F_ALE),
    .F_WEN     (F_WEN),
    .F_REN     (F_REN),
    .F_RB      (F_RB),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  function automatic logic [7:0] mdl(input logic [17:0] a);
    return a[7:0] ^ a[15:8] ^ {6'd0, a[17:16]} ^ 8'h3C;
  endfunction

  // Array model (one-cycle read latency) and write strobe counter.
  assign F_IO      = tb_oe ? tb_dq : 8'hzz;
  assign mem_rdata = rd_force ? 8'hA5 : r_mrd;
  always @(posedge clk) r_mrd <= mdl(mem_addr);
  always @(posedge clk) if (mem_we) we_cnt <= we_cnt + 1;

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic cle, input logic ale, input logic [7:0] d);
    F_CLE = cle; F_ALE = ale; tb_dq = d; tb_oe = 1'b1; F_WEN = 1'b0;
    tick(2);
    F_WEN = 1'b1;
    tick(1);
    tb_oe = 1'b0; F_CLE = 1'b0; F_ALE = 1'b0;
  endtask

  task automatic cmd_addr(input logic [7:0] c, input logic [7:0] a0,
                          input logic [7:0] a1, input logic [7:0] a2);
    wr(1'b1, 1'b0, c);
    wr(1'b0, 1'b1, a0);
    wr(1'b0, 1'b1, a1);
    wr(1'b0, 1'b1, a2);
  endtask

  task automatic rb_low(output int cnt);
    cnt = 0;
    while (F_RB === 1'b0 && cnt < 1000) begin
      cnt++;
      tick(1);
    end
  endtask

  task automatic rd_pulse(input string tag, input logic [17:0] ea);
    F_REN = 1'b0;
    tick(2);
    chk({tag, "_addr"}, 32'(mem_addr), 32'(ea));
    chk({tag, "_data"}, 32'(F_IO), 32'(mdl(ea)));
    F_REN = 1'b1;
    tick(2);
  endtask

  task automatic hiz_pulse(input string tag);
    rd_force = 1'b1;
    F_REN = 1'b0;
    tick(2);
    chk(tag, 32'(F_IO !== 8'hA5), 32'd1);
    F_REN = 1'b1;
    tick(2);
    rd_force = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; F_CLE = 1'b0; F_ALE = 1'b0; F_WEN = 1'b1; F_REN = 1'b1;
    tb_oe = 1'b0; tb_dq = 8'h00; rd_force = 1'b1;
    tick(3);
    chk("rst_rb",    32'(F_RB), 32'd1);
    chk("rst_we",    32'(mem_we), 32'd0);
    chk("rst_wdata", 32'(mem_wdata), 32'd0);
    chk("rst_addr",  32'(mem_addr), 32'd0);
    chk("rst_hiz",   32'(F_IO !== 8'hA5), 32'd1);
    rst = 1'b0; rd_force = 1'b0;
    tick(2);

    // Page 5 read, full page then wrap back to column 0.
    cmd_addr(8'h00, 8'h00, 8'h05, 8'h00);
    rb_low(n);
    chk("tr_busy", 32'(n), 32'd25);
    chk("tr_ready", 32'(F_RB), 32'd1);
    for (int i = 0; i < 512; i++) begin
      rd_pulse("rd_p5", {9'd5, 9'(i)});
    end
    chk("rd_p5_wrap", 32'(mem_addr), 32'h00A00);

    // 01h read (aborts current read) at page 511 column 272, wrap after 240 bytes.
    cmd_addr(8'h01, 8'h10, 8'hFF, 8'h01);
    rb_low(n);
    chk("tr_busy2", 32'(n), 32'd25);
    for (int i = 0; i < 242; i++) begin
      rd_pulse("rd_wrap", {9'd511, 9'(272 + i)});
    end

    // Synchronous reset while the target drives the bus.
    F_REN = 1'b0;
    tick(2);
    chk("drv_pre_rst", 32'(F_IO), 32'(mdl({9'd511, 9'd2})));
    rd_force = 1'b1;
    rst = 1'b1;
    tick(1);
    chk("rst_mid_hiz", 32'(F_IO !== 8'hA5), 32'd1);
    chk("rst_mid_rb",  32'(F_RB), 32'd1);
    chk("rst_mid_addr", 32'(mem_addr), 32'd0);
    rst = 1'b0; F_REN = 1'b1; rd_force = 1'b0;
    tick(2);

    // Unknown command and CLE+ALE together must not start an operation.
    cmd_addr(8'h90, 8'h00, 8'h05, 8'h00);
    wr(1'b1, 1'b1, 8'h00);
    wr(1'b0, 1'b1, 8'h07);
    wr(1'b0, 1'b1, 8'h09);
    wr(1'b0, 1'b1, 8'h00);
    tick(30);
    chk("unk_rb",   32'(F_RB), 32'd1);
    chk("unk_addr", 32'(mem_addr), 32'd0);
    hiz_pulse("unk_hiz");

    // Program page 3 with i^5A, confirm, then busy for T_PROG.
    cmd_addr(8'h80, 8'h00, 8'h03, 8'h00);
    chk("prog_rb", 32'(F_RB), 32'd1);
    we_base = we_cnt;
    for (int i = 0; i < 512; i++) begin
      wr(1'b0, 1'b0, 8'(i) ^ 8'h5A);
      chk("prog_we",    32'(mem_we), 32'd1);
      chk("prog_addr",  32'(mem_addr), 32'({9'd3, 9'(i)}));
      chk("prog_wdata", 32'(mem_wdata), 32'(8'(i) ^ 8'h5A));
    end
    wr(1'b1, 1'b0, 8'h10);
    chk("prog_we_cnt", 32'(we_cnt - we_base), 32'd512);
    rb_low(n);
    chk("tprog_busy", 32'(n), 32'd200);
    chk("tprog_ready", 32'(F_RB), 32'd1);
    hiz_pulse("prog_idle_hiz");

    // Reset command ten cycles into program busy.
    cmd_addr(8'h80, 8'h00, 8'h03, 8'h00);
    wr(1'b0, 1'b0, 8'h11);
    wr(1'b1, 1'b0, 8'h10);
    chk("bp_rb", 32'(F_RB), 32'd0);
    tick(9);
    wr(1'b1, 1'b0, 8'hFF);
    rb_low(n);
    chk("trst_busy", 32'(n), 32'd5);
    chk("trst_ready", 32'(F_RB), 32'd1);
    chk("trst_addr", 32'(mem_addr), 32'd0);
    hiz_pulse("trst_hiz");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
